rv_iopmp_entry_encoder: RTL and testbench
=========================================

# rv_iopmp_entry_encoder

Converts a requested protection region (byte base address, byte length, target entry index) into IOPMP entry register values (`addr`/`addrh` address field plus `mode_t`) and writes them into the entry table through a valid/ready write port. It selects the cheapest encoding: NA4, NAPOT, or a two-entry TOR pair. It sits between the configuration front end (software or a DMA descriptor walker) and the entry register file. Its encodings match what the entry matching logic decodes.

## Interface
- `LEN`, 32: width of each entry address register half.
- `ADDR_WIDTH`, 64: request address and size width. Must satisfy `ADDR_WIDTH <= 2*LEN+2`.
- `NUM_ENTRY`, 16: number of entries in the table.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low. One clock; no other reset.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  encoder idle and able to accept a request.
- `req_base_i`  in  ADDR_WIDTH  region base, in bytes.
- `req_size_i`  in  ADDR_WIDTH  region length, in bytes.
- `req_idx_i`  in  $clog2(NUM_ENTRY)  first entry index to program.
- `wr_valid_o`  out  1  entry write valid.
- `wr_ready_i`  in  1  entry table accepts the write.
- `wr_idx_o`  out  $clog2(NUM_ENTRY)  entry index being written.
- `wr_addr_o`, `wr_addrh_o`  out  LEN each  low and high halves of address field bits 65:2.
- `wr_mode_o`  out  rv_iopmp_pkg::mode_t  entry mode.
- `rsp_valid_o`  out  1  completion response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_err_o`  out  2  0 = OK, 1 = ZERO_SIZE, 2 = ALIGN, 3 = RANGE.
- `rsp_mode_o`  out  rv_iopmp_pkg::mode_t  encoding used (OFF on error).
- `rsp_count_o`  out  2  number of entries written (0, 1 or 2).

## Operation
- **FSM states:** IDLE, ENCODE, WRITE_A, WRITE_B, RESP.
- **IDLE:** `req_ready_o`=1. When `req_valid_i` is high, latch base, size and idx, then go to ENCODE. No other output is active.
- **ENCODE (1 cycle):** classify in this priority order:
  - `size==0` gives ZERO_SIZE.
  - `base[1:0]!=0` or `size[1:0]!=0` gives ALIGN.
  - `size==4` gives NA4, with `field = base>>2`.
  - size a power of two, `size>=8`, and `(base & (size-1))==0` gives NAPOT, with `field = (base>>2) | ((size>>3)-1)`.
  - Otherwise TOR. Entry `idx` gets `field = base>>2` with mode OFF. Entry `idx+1` gets `field = (base+size)>>2` with mode TOR.
  - TOR gives RANGE if `idx+1 >= NUM_ENTRY` or `base+size > 2^ADDR_WIDTH`. The sum is computed in ADDR_WIDTH+1 bits.
  - On error go to RESP. Otherwise register the write values and go to WRITE_A.
- **Field layout:** the field is zero-extended to 2*LEN bits. `wr_addr_o` is bits LEN-1:0 and `wr_addrh_o` is bits 2*LEN-1:LEN.
- **WRITE_A:** present the first entry. On `wr_valid_o && wr_ready_i`, go to WRITE_B if TOR, else go to RESP.
- **WRITE_B:** present entry `idx+1` with mode TOR. On handshake, go to RESP.
- **RESP:** `rsp_valid_o`=1 with err, mode and count. On `rsp_ready_i`, go to IDLE.
- **Ordering:** the OFF/base entry is always written before the TOR entry, so a partially written pair never matches.

## Timing
- **Reset values:** all outputs 0 except `req_ready_o`=1. State is IDLE. `wr_mode_o` and `rsp_mode_o` are OFF.
- **Reset mid-operation:** the request is abandoned immediately. No further writes and no response are issued.
- **Latency with `wr_ready_i` and `rsp_ready_i` tied high** (request accepted in cycle 0):
  - NA4/NAPOT: write in cycle 2, response in cycle 3, `req_ready_o` high again in cycle 4.
  - TOR: writes in cycles 2 and 3, response in cycle 4.
  - Error: response in cycle 2.
- **Outputs are registered and stable while waiting:**
  - `wr_*` must not change while `wr_valid_o` is high and `wr_ready_i` is low.
  - `rsp_*` must not change while `rsp_valid_o` is high and `rsp_ready_i` is low.
- **Back-to-back:** one request in flight at a time. `req_ready_o` is low outside IDLE, and `req_valid_i` is ignored there.
- **Sizes:** maximum NAPOT size is 2^(ADDR_WIDTH-1) because `size` is ADDR_WIDTH bits wide. A TOR end of exactly 2^ADDR_WIDTH is legal and encodes into field bit ADDR_WIDTH-2.

## Test plan
- **NAPOT:** base 0x8000_0000, size 0x1000, idx 3 -> one write: idx 3, addr 0x2000_01FF, addrh 0, NAPOT. Response OK, count 1, at cycle 3.
- **NA4:** base 0x10, size 4, idx 0 -> one write: addr 0x4, NA4. Response OK, count 1.
- **TOR:** base 0x1000, size 0x3000, idx 5 -> write idx 5 addr 0x400 OFF, then idx 6 addr 0x1000 TOR. Response TOR, count 2.
- **Errors, no `wr_valid_o` pulse in any case:**
  - size 6 -> ALIGN.
  - size 0 -> ZERO_SIZE.
  - TOR request with idx 15 and NUM_ENTRY 16 -> RANGE.
- **Backpressure:** TOR request with `wr_ready_i` low for 3 cycles in each write state, and `rsp_ready_i` low for 2 cycles -> `wr_*` and `rsp_*` held stable, exactly 2 writes, one response.
- **Reset mid-operation:** `rst_ni` asserted in WRITE_B -> all outputs at reset values in the same cycle. After release, `req_ready_o`=1, no stale write and no stale response.

Source files
------------

// File: rtl/rv_iopmp_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rv_iopmp_entry_encoder (and rv_iopmp_pkg)
// Brief    : Turns a (base, size, idx) protection region into IOPMP entry
//            writes. It picks NA4, NAPOT or a two-entry OFF/TOR pair, writes
//            the entries through a valid/ready port and then returns a
//            completion response.
// Revision : 1.0 - initial release
// ============================================================================

package rv_iopmp_pkg;
  // Entry address-matching mode, encoded as the entry matching logic decodes it
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } mode_t;
endpackage

module rv_iopmp_entry_encoder #(
  parameter int LEN        = 32,
  parameter int ADDR_WIDTH = 64,
  parameter int NUM_ENTRY  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [ADDR_WIDTH-1:0]        req_base_i,
  input  logic [ADDR_WIDTH-1:0]        req_size_i,
  input  logic [$clog2(NUM_ENTRY)-1:0] req_idx_i,
  output logic                         wr_valid_o,
  input  logic                         wr_ready_i,
  output logic [$clog2(NUM_ENTRY)-1:0] wr_idx_o,
  output logic [LEN-1:0]               wr_addr_o,
  output logic [LEN-1:0]               wr_addrh_o,
  output rv_iopmp_pkg::mode_t          wr_mode_o,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [1:0]                   rsp_err_o,
  output rv_iopmp_pkg::mode_t          rsp_mode_o,
  output logic [1:0]                   rsp_count_o
);

  localparam int IW = $clog2(NUM_ENTRY);
  localparam int FW = 2 * LEN;
  localparam int SW = ADDR_WIDTH + 1;
  // Arithmetic width wide enough for the carry of base+size and for the field
  localparam int XW = (SW > FW) ? SW : FW;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ZERO  = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_RANGE = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENCODE  = 3'd1,
    S_WRITE_A = 3'd2,
    S_WRITE_B = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   size_q;
  logic [IW-1:0]           idx_q;
  rv_iopmp_pkg::mode_t     mode_q;
  logic [FW-1:0]           field_b_q;

  logic                    req_ready_q;
  logic                    wr_valid_q;
  logic [IW-1:0]           wr_idx_q;
  logic [FW-1:0]           wr_field_q;
  rv_iopmp_pkg::mode_t     wr_mode_q;
  logic                    rsp_valid_q;
  logic [1:0]              rsp_err_q;
  rv_iopmp_pkg::mode_t     rsp_mode_q;
  logic [1:0]              rsp_count_q;

  // Encoder results, consumed only in ENCODE
  logic [XW-1:0]           base_x;
  logic [XW-1:0]           size_x;
  logic [XW-1:0]           end_x;
  logic [XW-1:0]           limit_x;
  logic [IW:0]             idx_inc;
  logic                    size_pow2;
  logic                    tor_range;
  logic [1:0]              err_d;
  rv_iopmp_pkg::mode_t     mode_d;
  logic [FW-1:0]           field_a_d;
  logic [FW-1:0]           field_b_d;

  assign base_x    = XW'(base_q);
  assign size_x    = XW'(size_q);
  assign end_x     = base_x + size_x;
  assign limit_x   = XW'(1) << ADDR_WIDTH;
  assign idx_inc   = {1'b0, idx_q} + (IW+1)'(1);
  assign size_pow2 = ((size_x & (size_x - XW'(1))) == '0);
  // A TOR pair needs a second entry, and its end may reach but not pass the top
  assign tor_range = (idx_inc >= (IW+1)'(NUM_ENTRY)) || (end_x > limit_x);

  // Classify the latched request and compute both candidate address fields
  always_comb begin
    err_d     = ERR_OK;
    mode_d    = rv_iopmp_pkg::OFF;
    field_a_d = FW'(base_x >> 2);
    field_b_d = FW'(end_x >> 2);
    if (size_q == '0) begin
      err_d = ERR_ZERO;
    end else if ((base_q[1:0] != 2'b00) || (size_q[1:0] != 2'b00)) begin
      err_d = ERR_ALIGN;
    end else if (size_x == XW'(4)) begin
      mode_d = rv_iopmp_pkg::NA4;
    end else if (size_pow2 && (size_x >= XW'(8)) &&
                 ((base_x & (size_x - XW'(1))) == '0)) begin
      mode_d    = rv_iopmp_pkg::NAPOT;
      field_a_d = FW'((base_x >> 2) | ((size_x >> 3) - XW'(1)));
    end else begin
      mode_d = rv_iopmp_pkg::TOR;
      if (tor_range) begin
        err_d = ERR_RANGE;
      end
    end
  end

  // Control FSM; every output is driven straight from a register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      size_q      <= '0;
      idx_q       <= '0;
      mode_q      <= rv_iopmp_pkg::OFF;
      field_b_q   <= '0;
      req_ready_q <= 1'b1;
      wr_valid_q  <= 1'b0;
      wr_idx_q    <= '0;
      wr_field_q  <= '0;
      wr_mode_q   <= rv_iopmp_pkg::OFF;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      rsp_mode_q  <= rv_iopmp_pkg::OFF;
      rsp_count_q <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            base_q      <= req_base_i;
            size_q      <= req_size_i;
            idx_q       <= req_idx_i;
            req_ready_q <= 1'b0;
            state_q     <= S_ENCODE;
          end
        end
        S_ENCODE: begin
          if (err_d != ERR_OK) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_d;
            rsp_mode_q  <= rv_iopmp_pkg::OFF;
            rsp_count_q <= 2'd0;
            state_q     <= S_RESP;
          end else begin
            mode_q     <= mode_d;
            field_b_q  <= field_b_d;
            wr_valid_q <= 1'b1;
            wr_idx_q   <= idx_q;
            wr_field_q <= field_a_d;
            // The base entry of a TOR pair stays OFF so a half-written pair never matches
            wr_mode_q  <= (mode_d == rv_iopmp_pkg::TOR) ? rv_iopmp_pkg::OFF : mode_d;
            state_q    <= S_WRITE_A;
          end
        end
        S_WRITE_A: begin
          if (wr_ready_i) begin
            if (mode_q == rv_iopmp_pkg::TOR) begin
              wr_idx_q   <= idx_inc[IW-1:0];
              wr_field_q <= field_b_q;
              wr_mode_q  <= rv_iopmp_pkg::TOR;
              state_q    <= S_WRITE_B;
            end else begin
              wr_valid_q  <= 1'b0;
              wr_idx_q    <= '0;
              wr_field_q  <= '0;
              wr_mode_q   <= rv_iopmp_pkg::OFF;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= ERR_OK;
              rsp_mode_q  <= mode_q;
              rsp_count_q <= 2'd1;
              state_q     <= S_RESP;
            end
          end
        end
        S_WRITE_B: begin
          if (wr_ready_i) begin
            wr_valid_q  <= 1'b0;
            wr_idx_q    <= '0;
            wr_field_q  <= '0;
            wr_mode_q   <= rv_iopmp_pkg::OFF;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_OK;
            rsp_mode_q  <= rv_iopmp_pkg::TOR;
            rsp_count_q <= 2'd2;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= ERR_OK;
            rsp_mode_q  <= rv_iopmp_pkg::OFF;
            rsp_count_q <= 2'd0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_idx_o    = wr_idx_q;
  assign wr_addr_o   = wr_field_q[LEN-1:0];
  assign wr_addrh_o  = wr_field_q[FW-1:LEN];
  assign wr_mode_o   = wr_mode_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_mode_o  = rsp_mode_q;
  assign rsp_count_o = rsp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_iopmp_entry_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_iopmp_entry_encoder
// Brief    : Directed self-checking bench for rv_iopmp_entry_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_iopmp_entry_encoder;

  localparam logic [1:0] M_OFF = 2'd0, M_TOR = 2'd1, M_NA4 = 2'd2, M_NAPOT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_base = '0;
  logic [63:0] req_size = '0;
  logic [3:0]  req_idx = '0;
  logic        wr_valid;
  logic        wr_ready = 1'b1;
  logic [3:0]  wr_idx;
  logic [31:0] wr_addr, wr_addrh;
  rv_iopmp_pkg::mode_t wr_mode;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_err;
  rv_iopmp_pkg::mode_t rsp_mode;
  logic [1:0]  rsp_count;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_hs = 0, rsp_hs = 0, wr_vld_cycles = 0;

  // {valid, idx, addrh, addr, mode} and {valid, err, mode, count}
  logic [70:0] wr_vec;
  logic [6:0]  rsp_vec;
  assign wr_vec  = {wr_valid, wr_idx, wr_addrh, wr_addr, wr_mode};
  assign rsp_vec = {rsp_valid, rsp_err, rsp_mode, rsp_count};

  rv_iopmp_entry_encoder #(.LEN(32), .ADDR_WIDTH(64), .NUM_ENTRY(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_base_i  (req_base),
    .req_size_i  (req_size),
    .req_idx_i   (req_idx),
    .wr_valid_o  (wr_valid),
    .wr_ready_i  (wr_ready),
    .wr_idx_o    (wr_idx),
    .wr_addr_o   (wr_addr),
    .wr_addrh_o  (wr_addrh),
    .wr_mode_o   (wr_mode),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_err_o   (rsp_err),
    .rsp_mode_o  (rsp_mode),
    .rsp_count_o (rsp_count)
  );

  always #5 clk = ~clk;

  // Handshake and activity counters
  always @(posedge clk) begin
    if (wr_valid && wr_ready) wr_hs++;
    if (rsp_valid && rsp_ready) rsp_hs++;
    if (wr_valid) wr_vld_cycles++;
  end

  // Present a request for one cycle; returns just after the accepting edge (cycle 0)
  task automatic issue(input logic [63:0] b, input logic [63:0] s, input logic [3:0] i);
    @(negedge clk);
    req_valid = 1'b1;
    req_base  = b;
    req_size  = s;
    req_idx   = i;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, wr_vec, rsp_vec} !== {1'b1, 71'd0, 7'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b wr=%h rsp=%h, want rdy=1 wr=0 rsp=0", req_ready, wr_vec, rsp_vec);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({req_ready, wr_valid, rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got rdy/wv/rv=%b, want 100", {req_ready, wr_valid, rsp_valid});
    end
  endtask

  task automatic test_napot();
    wr_ready = 1'b1; rsp_ready = 1'b1;
    issue(64'h8000_0000, 64'h1000, 4'd3);
    @(negedge clk); // cycle 1
    n_checks++;
    if ({req_ready, wr_valid, rsp_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL napot_encode_cycle: got rdy/wv/rv=%b, want 000", {req_ready, wr_valid, rsp_valid});
    end
    @(negedge clk); // cycle 2
    n_checks++;
    if (wr_vec !== {1'b1, 4'd3, 32'h0, 32'h2000_01FF, M_NAPOT}) begin
      n_fail++;
      $display("FAIL napot_write: got %h, want %h", wr_vec, {1'b1, 4'd3, 32'h0, 32'h2000_01FF, M_NAPOT});
    end
    @(negedge clk); // cycle 3
    n_checks++;
    if ({wr_valid, rsp_vec} !== {1'b0, 1'b1, 2'd0, M_NAPOT, 2'd1}) begin
      n_fail++;
      $display("FAIL napot_resp: got wv=%b rsp=%h, want wv=0 rsp=%h", wr_valid, rsp_vec, {1'b1, 2'd0, M_NAPOT, 2'd1});
    end
    @(negedge clk); // cycle 4
    n_checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL napot_idle_again: got rdy/rv=%b, want 10", {req_ready, rsp_valid});
    end
  endtask

  // NA4 while req_valid is held high with other values during the busy cycles
  task automatic test_na4_busy_ignore();
    wr_vld_cycles = 0; rsp_hs = 0;
    issue(64'h10, 64'h4, 4'd0);
    req_valid = 1'b1; req_base = 64'h5000; req_size = 64'h3000; req_idx = 4'd9;
    @(negedge clk); // cycle 1
    @(negedge clk); // cycle 2
    n_checks++;
    if (wr_vec !== {1'b1, 4'd0, 32'h0, 32'h4, M_NA4}) begin
      n_fail++;
      $display("FAIL na4_write: got %h, want %h", wr_vec, {1'b1, 4'd0, 32'h0, 32'h4, M_NA4});
    end
    @(negedge clk); // cycle 3
    n_checks++;
    if ({req_ready, rsp_vec} !== {1'b0, 1'b1, 2'd0, M_NA4, 2'd1}) begin
      n_fail++;
      $display("FAIL na4_resp: got rdy=%b rsp=%h, want rdy=0 rsp=%h", req_ready, rsp_vec, {1'b1, 2'd0, M_NA4, 2'd1});
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wr_vld_cycles, rsp_hs, req_ready} !== {32'd1, 32'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL na4_single_txn: got wcyc=%0d rsp=%0d rdy=%b, want 1 1 1", wr_vld_cycles, rsp_hs, req_ready);
    end
  endtask

  task automatic test_tor(input logic [63:0] b, input logic [63:0] s, input logic [3:0] i,
                          input logic [70:0] exp_a, input logic [70:0] exp_b, input string nm);
    wr_ready = 1'b1; rsp_ready = 1'b1;
    issue(b, s, i);
    @(negedge clk); // cycle 1
    @(negedge clk); // cycle 2
    n_checks++;
    if (wr_vec !== exp_a) begin
      n_fail++;
      $display("FAIL %s_write_a: got %h, want %h", nm, wr_vec, exp_a);
    end
    @(negedge clk); // cycle 3
    n_checks++;
    if (wr_vec !== exp_b) begin
      n_fail++;
      $display("FAIL %s_write_b: got %h, want %h", nm, wr_vec, exp_b);
    end
    @(negedge clk); // cycle 4
    n_checks++;
    if ({wr_valid, rsp_vec} !== {1'b0, 1'b1, 2'd0, M_TOR, 2'd2}) begin
      n_fail++;
      $display("FAIL %s_resp: got wv=%b rsp=%h, want wv=0 rsp=%h", nm, wr_valid, rsp_vec, {1'b1, 2'd0, M_TOR, 2'd2});
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [63:0] t_base [5];
    logic [63:0] t_size [5];
    logic [3:0]  t_idx  [5];
    logic [1:0]  t_err  [5];
    t_base[0] = 64'h100;                 t_size[0] = 64'h6;    t_idx[0] = 4'd0;  t_err[0] = 2'd2;
    t_base[1] = 64'h100;                 t_size[1] = 64'h0;    t_idx[1] = 4'd0;  t_err[1] = 2'd1;
    t_base[2] = 64'h1000;                t_size[2] = 64'h3000; t_idx[2] = 4'd15; t_err[2] = 2'd3;
    t_base[3] = 64'hFFFF_FFFF_FFFF_E000; t_size[3] = 64'h3000; t_idx[3] = 4'd0;  t_err[3] = 2'd3;
    t_base[4] = 64'h102;                 t_size[4] = 64'h8;    t_idx[4] = 4'd0;  t_err[4] = 2'd2;
    wr_ready = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wr_vld_cycles = 0;
      issue(t_base[k], t_size[k], t_idx[k]);
      @(negedge clk); // cycle 1
      @(negedge clk); // cycle 2
      n_checks++;
      if (rsp_vec !== {1'b1, t_err[k], M_OFF, 2'd0}) begin
        n_fail++;
        $display("FAIL err_case%0d_resp: got %h, want %h", k, rsp_vec, {1'b1, t_err[k], M_OFF, 2'd0});
      end
      @(negedge clk); // cycle 3
      n_checks++;
      if ({req_ready, wr_vld_cycles} !== {1'b1, 32'd0}) begin
        n_fail++;
        $display("FAIL err_case%0d_nowrite: got rdy=%b wcyc=%0d, want rdy=1 wcyc=0", k, req_ready, wr_vld_cycles);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [70:0] ea, eb;
    ea = {1'b1, 4'd5, 32'h0, 32'h400, M_OFF};
    eb = {1'b1, 4'd6, 32'h0, 32'h1000, M_TOR};
    wr_ready = 1'b0; rsp_ready = 1'b0; wr_hs = 0; rsp_hs = 0;
    issue(64'h1000, 64'h3000, 4'd5);
    @(negedge clk); // cycle 1
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) wr_ready = 1'b1;
      n_checks++;
      if (wr_vec !== ea) begin
        n_fail++;
        $display("FAIL bp_hold_a%0d: got %h, want %h", k, wr_vec, ea);
      end
    end
    @(posedge clk); #1 wr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) wr_ready = 1'b1;
      n_checks++;
      if (wr_vec !== eb) begin
        n_fail++;
        $display("FAIL bp_hold_b%0d: got %h, want %h", k, wr_vec, eb);
      end
    end
    @(posedge clk); #1 wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) rsp_ready = 1'b1;
      n_checks++;
      if ({wr_valid, rsp_vec} !== {1'b0, 1'b1, 2'd0, M_TOR, 2'd2}) begin
        n_fail++;
        $display("FAIL bp_hold_rsp%0d: got wv=%b rsp=%h, want wv=0 rsp=%h", k, wr_valid, rsp_vec, {1'b1, 2'd0, M_TOR, 2'd2});
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, wr_hs, rsp_hs} !== {1'b1, 32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL bp_counts: got rdy=%b wr=%0d rsp=%0d, want 1 2 1", req_ready, wr_hs, rsp_hs);
    end
    wr_ready = 1'b1; rsp_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    wr_ready = 1'b1; rsp_ready = 1'b1;
    issue(64'h1000, 64'h3000, 4'd5);
    repeat (3) @(negedge clk); // cycle 3 = WRITE_B
    n_checks++;
    if ({wr_valid, wr_idx} !== {1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL rstmid_in_write_b: got wv=%b idx=%0d, want wv=1 idx=6", wr_valid, wr_idx);
    end
    #1 rst_n = 1'b0;
    wr_hs = 0; rsp_hs = 0; wr_vld_cycles = 0;
    #1;
    n_checks++;
    if ({req_ready, wr_vec, rsp_vec} !== {1'b1, 71'd0, 7'd0}) begin
      n_fail++;
      $display("FAIL rstmid_immediate: got rdy=%b wr=%h rsp=%h, want rdy=1 wr=0 rsp=0", req_ready, wr_vec, rsp_vec);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({req_ready, wr_vld_cycles, rsp_hs, rsp_valid} !== {1'b1, 32'd0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_no_stale: got rdy=%b wcyc=%0d rsp=%0d rv=%b, want 1 0 0 0", req_ready, wr_vld_cycles, rsp_hs, rsp_valid);
    end
    issue(64'h20, 64'h4, 4'd2);
    repeat (2) @(negedge clk);
    n_checks++;
    if (wr_vec !== {1'b1, 4'd2, 32'h0, 32'h8, M_NA4}) begin
      n_fail++;
      $display("FAIL rstmid_recover: got %h, want %h", wr_vec, {1'b1, 4'd2, 32'h0, 32'h8, M_NA4});
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_napot();
    test_na4_busy_ignore();
    test_tor(64'h1000, 64'h3000, 4'd5,
             {1'b1, 4'd5, 32'h0, 32'h400, M_OFF},
             {1'b1, 4'd6, 32'h0, 32'h1000, M_TOR}, "tor");
    test_tor(64'hFFFF_FFFF_FFFF_D000, 64'h3000, 4'd0,
             {1'b1, 4'd0, 32'h3FFF_FFFF, 32'hFFFF_F400, M_OFF},
             {1'b1, 4'd1, 32'h4000_0000, 32'h0, M_TOR}, "tor_top");
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
